// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI slave front end and the RAM controller.
// The SPI side is the master: it issues command words and receives read data and pulses.
interface spi_ram_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              addr_err;

  modport master (output rx_valid, din, input dout, tx_valid, addr_err);
  modport slave  (input rx_valid, din, output dout, tx_valid, addr_err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoded single-port RAM with independent write/read pointers,
// optional burst auto-increment and 1- or 2-cycle read latency.
module spi_ram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1,
  parameter int READ_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_ram_ctrl_if.slave bus
);
  localparam logic [1:0] CMD_SET_WR = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_SET_RD = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic              addr_err_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              tx_valid_reg;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              wr_en;
  logic              rd_en;

  assign cmd     = bus.din[DATA_W+1:DATA_W];
  assign payload = bus.din[DATA_W-1:0];
  assign addr    = payload[ADDR_W-1:0];
  // The shift form also covers ADDR_W == DATA_W, where there are no upper bits.
  assign addr_ok = ((payload >> ADDR_W) == '0) && ({1'b0, addr} < DEPTH_C);

  // Reset has priority, so neither the RAM nor the read path may act during it.
  assign wr_en = rst_n && bus.rx_valid && (cmd == CMD_WRITE);
  assign rd_en = rst_n && bus.rx_valid && (cmd == CMD_READ);

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= 1'b0;
      if (bus.rx_valid) begin
        case (cmd)
          CMD_SET_WR: begin
            if (addr_ok) wr_ptr_reg <= addr;
            else         addr_err_reg <= 1'b1;
          end
          CMD_WRITE: begin
            if (AUTO_INC != 0) wr_ptr_reg <= next_ptr(wr_ptr_reg);
          end
          CMD_SET_RD: begin
            if (addr_ok) rd_ptr_reg <= addr;
            else         addr_err_reg <= 1'b1;
          end
          default: begin
            if (AUTO_INC != 0) rd_ptr_reg <= next_ptr(rd_ptr_reg);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= payload;
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dout_reg     <= '0;
          tx_valid_reg <= 1'b0;
        end else begin
          tx_valid_reg <= rd_en;
          if (rd_en) dout_reg <= mem[rd_ptr_reg];
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] stage_reg;
      logic              stage_valid_reg;

      // Data stage carries no reset so it maps onto the RAM's own read register.
      always_ff @(posedge clk) begin
        if (rd_en) stage_reg <= mem[rd_ptr_reg];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          stage_valid_reg <= 1'b0;
          dout_reg        <= '0;
          tx_valid_reg    <= 1'b0;
        end else begin
          stage_valid_reg <= rd_en;
          tx_valid_reg    <= stage_valid_reg;
          if (stage_valid_reg) dout_reg <= stage_reg;
        end
      end
    end
  endgenerate

  assign bus.dout     = dout_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.addr_err = addr_err_reg;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Drives one shared command stream into four controller configurations, each
// checked by its own reference model and scoreboard.
module tb_spi_ram_ctrl;
  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [9:0] din = '0;
  int         n_cmp = 0;
  int         n_bad = 0;

  initial forever #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int DEPTH = (gi < 2) ? 256 : 200;
    localparam int AUTO  = (gi == 1 || gi == 2) ? 1 : 0;
    localparam int LAT   = (gi >= 2) ? 2 : 1;

    spi_ram_ctrl_if #(.DATA_W(8)) bus ();
    assign bus.rx_valid = rx_valid;
    assign bus.din      = din;

    spi_ram_ctrl #(
      .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(DEPTH), .AUTO_INC(AUTO), .READ_LAT(LAT)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    rd_t        rdq[$];
    int         errq[$];
    int         rstq[$];
    logic [7:0] mem_m [DEPTH];
    int         wr_m = 0;
    int         rd_m = 0;
    int         edge_n = 0;
    int         neg_n = 0;
    logic [7:0] last_dout = '0;

    // Reference model: applies each sampled command with plain integer arithmetic.
    always @(posedge clk) begin
      int p;
      edge_n++;
      p = int'(din[7:0]);
      if (!rst_n) begin
        wr_m = 0;
        rd_m = 0;
        while (rdq.size() > 0 && rdq[$].cyc >= edge_n) void'(rdq.pop_back());
        rstq.push_back(edge_n);
      end else if (rx_valid) begin
        case (din[9:8])
          2'b00: if (p < DEPTH) wr_m = p; else errq.push_back(edge_n);
          2'b01: begin
            mem_m[wr_m] = din[7:0];
            if (AUTO == 1) wr_m = (wr_m + 1) % DEPTH;
          end
          2'b10: if (p < DEPTH) rd_m = p; else errq.push_back(edge_n);
          default: begin
            rdq.push_back('{cyc: edge_n + LAT - 1, data: mem_m[rd_m]});
            if (AUTO == 1) rd_m = (rd_m + 1) % DEPTH;
          end
        endcase
      end
    end

    // Monitor: pops expectations as the DUT presents results.
    always @(negedge clk) begin
      logic exp_tx;
      logic exp_err;
      neg_n++;
      if (rstq.size() > 0 && rstq[0] == neg_n) begin
        void'(rstq.pop_front());
        last_dout = '0;
      end
      while (rdq.size() > 0 && rdq[0].cyc < neg_n) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cfg%0d missed_read cyc=%0d got=none exp_data=%h", gi, rdq[0].cyc, rdq[0].data);
        void'(rdq.pop_front());
      end
      exp_tx = (rdq.size() > 0) && (rdq[0].cyc == neg_n);
      n_cmp++;
      if (bus.tx_valid !== exp_tx) begin
        n_bad++;
        $display("FAIL cfg%0d tx_valid cyc=%0d got=%b exp=%b", gi, neg_n, bus.tx_valid, exp_tx);
      end
      if (exp_tx) begin
        last_dout = rdq[0].data;
        void'(rdq.pop_front());
        $display("cfg%0d read cyc=%0d dout=%h exp=%h", gi, neg_n, bus.dout, last_dout);
      end
      n_cmp++;
      if (bus.dout !== last_dout) begin
        n_bad++;
        $display("FAIL cfg%0d dout cyc=%0d got=%h exp=%h", gi, neg_n, bus.dout, last_dout);
      end
      exp_err = (errq.size() > 0) && (errq[0] == neg_n);
      if (exp_err) void'(errq.pop_front());
      n_cmp++;
      if (bus.addr_err !== exp_err) begin
        n_bad++;
        $display("FAIL cfg%0d addr_err cyc=%0d got=%b exp=%b", gi, neg_n, bus.addr_err, exp_err);
      end
    end
  end

  task automatic drive(input logic rv, input logic [1:0] c, input logic [7:0] p, input logic r);
    @(posedge clk);
    #2;
    rst_n    = r;
    rx_valid = rv;
    din      = {c, p};
  endtask

  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    drive(1'b1, c, p, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 8'(i * 37), 1'b1);
  endtask

  task automatic reset_pulse();
    drive(1'b1, 2'b01, 8'hEE, 1'b0);
  endtask

  initial begin
    logic [7:0] p;
    int         r;
    // Fill every location so no read can ever return uninitialised data.
    idle(1);
    for (int a = 0; a < 256; a++) begin
      cmd(2'b00, 8'(a));
      cmd(2'b01, 8'($urandom));
    end

    // Basic write/read.
    reset_pulse();
    cmd(2'b00, 8'h12); cmd(2'b01, 8'hA5); cmd(2'b10, 8'h12); cmd(2'b11, 8'h00);
    idle(2);
    // Burst across the top of a 256-word memory.
    cmd(2'b00, 8'hFE); cmd(2'b01, 8'h11); cmd(2'b01, 8'h22); cmd(2'b01, 8'h33);
    cmd(2'b10, 8'hFE); cmd(2'b11, 8'h00); cmd(2'b11, 8'h00); cmd(2'b11, 8'h00);
    idle(2);
    // Range boundary for a 200-word memory.
    cmd(2'b00, 8'h10); cmd(2'b00, 8'hC8); cmd(2'b01, 8'h5A);
    cmd(2'b00, 8'hC7); cmd(2'b01, 8'h6B); cmd(2'b10, 8'hC8); cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00); cmd(2'b10, 8'hC7); cmd(2'b11, 8'h00);
    idle(2);
    // Reset immediately after a read, then write-then-read of the same word.
    cmd(2'b10, 8'h05); cmd(2'b11, 8'h00); reset_pulse();
    cmd(2'b01, 8'h77); cmd(2'b11, 8'h00);
    // Gap of five idle cycles between reads.
    cmd(2'b11, 8'h00); idle(5); cmd(2'b11, 8'h00);
    // Reset mid-burst, then read back the surviving data from address 0.
    cmd(2'b00, 8'h00); cmd(2'b01, 8'h9C); cmd(2'b01, 8'h9D); reset_pulse();
    cmd(2'b11, 8'h00); cmd(2'b11, 8'h00);
    idle(3);

    // Randomised traffic biased toward the range and wrap boundaries.
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 3))
        0:       p = 8'hC7 + 8'($urandom_range(0, 1));
        1:       p = 8'hFE + 8'($urandom_range(0, 1));
        default: p = 8'($urandom);
      endcase
      if (r < 2)       reset_pulse();
      else if (r < 20) drive(1'b0, 2'($urandom), p, 1'b1);
      else             cmd(2'($urandom), p);
    end
    idle(6);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
